// File: rtl/vram_arbiter.sv
// vram_arbiter: two-requester SDRAM FIFO arbiter with a per-transaction wait timeout.
// Define VRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority to requester 0 otherwise.
module vram_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                busy,
  output logic                write,
  output logic                read,
  output logic [ADDR_W-1:0]   writeaddr,
  output logic [ADDR_W-1:0]   readaddr,
  output logic [DATA_W-1:0]   writedata,
  input  logic                wr_full,
  input  logic                rd_empty,
  input  logic [DATA_W-1:0]   readdata
);
  localparam logic [2:0] IDLE = 3'd0, WR_ISSUE = 3'd1, WR_WAIT = 3'd2, RD_ISSUE = 3'd3, RD_WAIT = 3'd4;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  logic [2:0]        r_state;
  logic              r_win;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_cnt;
  logic [1:0]        r_done;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;
  logic              w_win;
  logic              w_ready;
`ifdef VRAM_ARB_ROUND_ROBIN_EN
  logic r_last;
  assign w_win = (req == 2'b11) ? ~r_last : req[1];
  always_ff @(posedge clk or posedge reset)
    if (reset) r_last <= 1'b1;
    else if (r_state == IDLE && |req) r_last <= w_win;
`else
  assign w_win = ~req[0];
`endif
  assign w_ready = (r_state == WR_WAIT) ? ~wr_full : ~rd_empty;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_win   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_done  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        IDLE: if (|req) begin
          r_win   <= w_win;
          r_addr  <= w_win ? addr[ADDR_W +: ADDR_W] : addr[0 +: ADDR_W];
          r_wdata <= w_win ? wdata[DATA_W +: DATA_W] : wdata[0 +: DATA_W];
          r_state <= we[w_win] ? WR_ISSUE : RD_ISSUE;
        end
        WR_ISSUE, RD_ISSUE: begin
          r_cnt   <= '0;
          r_state <= (r_state == WR_ISSUE) ? WR_WAIT : RD_WAIT;
        end
        WR_WAIT, RD_WAIT:
          // a FIFO ready in the final counted cycle still completes normally
          if (w_ready || r_cnt == LAST) begin
            r_state       <= IDLE;
            r_done[r_win] <= 1'b1;
            r_err         <= ~w_ready;
            r_rdata       <= (r_state == RD_WAIT && w_ready) ? readdata : '0;
          end else r_cnt <= r_cnt + 8'd1;
        default: r_state <= IDLE;
      endcase
    end
  assign busy      = r_state != IDLE;
  assign write     = r_state == WR_ISSUE;
  assign read      = r_state == RD_ISSUE;
  assign gnt       = (write || read) ? (r_win ? 2'b10 : 2'b01) : 2'b00;
  assign writeaddr = write ? r_addr : '0;
  assign writedata = write ? r_wdata : '0;
  assign readaddr  = read ? r_addr : '0;
  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized scoreboard bench; a driver queues expected grants and completions,
// a negedge monitor pops and compares them as the arbiter presents them.
module tb_vram_arbiter;
  localparam int AW = 16, DW = 16, TO = 255;
  logic clk = 0, reset = 1;
  logic [1:0] req = 0, we = 0;
  logic [2*AW-1:0] addr = 0;
  logic [2*DW-1:0] wdata = 0;
  logic wr_full = 0, rd_empty = 0;
  logic [DW-1:0] readdata = 0;
  logic [1:0] gnt, done;
  logic [DW-1:0] rdata, writedata;
  logic err, busy, write, read;
  logic [AW-1:0] writeaddr, readaddr;
  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err), .busy(busy),
    .write(write), .read(read), .writeaddr(writeaddr), .readaddr(readaddr),
    .writedata(writedata), .wr_full(wr_full), .rd_empty(rd_empty), .readdata(readdata)
  );
  always #5 clk = ~clk;
  int checks = 0, fails = 0, cyc = 0;
  bit last = 1;
  typedef struct { logic [1:0] g; logic w; logic [AW-1:0] a; logic [DW-1:0] d; } iss_t;
  typedef struct { logic [1:0] d; logic e; logic [DW-1:0] r; int at; } cmp_t;
  iss_t iq[$];
  cmp_t cq[$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  iss_t me;
  cmp_t mc;
  always @(negedge clk) if (!reset) begin
    if (gnt != 0) begin
      if (iq.size() == 0) chk("unexpected gnt", gnt, 0);
      else begin
        me = iq.pop_front();
        chk("gnt", gnt, me.g);
        chk("write strobe", write, me.w);
        chk("read strobe", read, !me.w);
        chk("issue addr", me.w ? writeaddr : readaddr, me.a);
        if (me.w) chk("writedata", writedata, me.d);
      end
    end else chk("strobes without gnt", {write, read}, 0);
    if (!write) chk("write bus quiet", {writeaddr, writedata}, 0);
    if (!read) chk("read bus quiet", readaddr, 0);
    if (done != 0) begin
      chk("done with gnt", gnt, 0);
      if (cq.size() == 0) chk("unexpected done", done, 0);
      else begin
        mc = cq.pop_front();
        chk("done", done, mc.d);
        chk("err", err, mc.e);
        chk("rdata", rdata, mc.r);
        chk("done cycle", cyc, mc.at);
      end
    end
  end
  function automatic int pick(logic [1:0] r);
    int w;
    if (r == 2'b11) begin
`ifdef VRAM_ARB_ROUND_ROBIN_EN
      w = last ? 0 : 1;
`else
      w = 0;
`endif
    end else w = (r == 2'b10) ? 1 : 0;
    last = (w == 1);
    return w;
  endfunction
  // s = number of WAIT cycles the FIFO stays not-ready; s >= TO never releases (timeout)
  task automatic txn(logic [1:0] r, logic [1:0] w, logic [2*AW-1:0] a, logic [2*DW-1:0] d,
                     logic [DW-1:0] rd, int s, bit hold);
    int win, t0, k;
    bit ok;
    iss_t e;
    cmp_t c;
    req = r; we = w; addr = a; wdata = d; readdata = rd;
    win = pick(r);
    e.g = 2'(1 << win); e.w = w[win];
    e.a = win ? a[AW +: AW] : a[0 +: AW];
    e.d = win ? d[DW +: DW] : d[0 +: DW];
    iq.push_back(e);
    t0 = cyc;
    k = 0;
    do begin @(negedge clk); k++; end while (gnt == 0 && k < 4);
    chk("grant latency", cyc - t0, 1);
    if (!hold) req = 0;
    wr_full = 1; rd_empty = 1;
    ok = s < TO;
    c.d = e.g; c.e = !ok; c.r = (!e.w && ok) ? rd : '0;
    c.at = cyc + 1 + (ok ? s + 1 : TO);
    cq.push_back(c);
    if (ok) begin
      repeat (s + 1) @(negedge clk);
      wr_full = 0; rd_empty = 0;
    end
    k = 0;
    do begin @(negedge clk); k++; end while (busy && k < TO + 10);
    chk("completion wait", busy, 0);
    wr_full = 0; rd_empty = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #1 chk("reset outputs", {gnt, done, rdata, err, busy, write, read, writeaddr, readaddr, writedata}, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    for (int i = 0; i < 4; i++) txn(2'b11, 2'b00, $urandom, $urandom, 16'($urandom), 0, 1);
    req = 0;
    txn(2'b01, 2'b00, {16'h0, 16'h0003}, 0, 16'h0003, 1, 0);
    txn(2'b10, 2'b10, {16'h0001, 16'h0}, {16'h00AA, 16'h0}, 0, 4, 0);
    txn(2'b01, 2'b00, $urandom, $urandom, 16'hBEEF, TO, 0);
    txn(2'b10, 2'b00, $urandom, $urandom, 16'h1234, TO - 1, 0);
    txn(2'b01, 2'b01, $urandom, $urandom, 0, TO, 0);
    for (int i = 0; i < 40; i++)
      txn(2'($urandom_range(1, 3)), 2'($urandom), $urandom, $urandom, 16'($urandom),
          $urandom_range(0, 5), 1'($urandom));
    req = 0;
    txn(2'b10, 2'b10, $urandom, $urandom, 0, 0, 0);
    req = 2'b10; we = 2'b10; addr = 32'h00050000; wdata = 32'h00660000;
    me.g = 2'b10; me.w = 1; me.a = 16'h0005; me.d = 16'h0066;
    iq.push_back(me);
    void'(pick(2'b10));
    wr_full = 1;
    for (int k = 0; k < 4 && gnt == 0; k++) @(negedge clk);
    req = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    #1 chk("reset mid-wait outputs", {gnt, done, rdata, err, busy, write, read, writeaddr, readaddr, writedata}, 0);
    last = 1;
    repeat (2) @(negedge clk);
    chk("no done in reset", done, 0);
    reset = 0; wr_full = 0;
    txn(2'b01, 2'b00, $urandom, $urandom, 16'h5A5A, 2, 0);
    repeat (3) @(negedge clk);
    chk("pending expectations", iq.size() + cq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, SDRAM FIFO address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, SDRAM FIFO data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, maximum wait cycles per transaction (8-bit counter).
REQ-004 The block SHALL use one clock and asynchronous active-high reset: clk  in  1  rising-edge clock.
REQ-005 The block SHALL have reset  in  1  asynchronous active-high reset.
REQ-006 The block SHALL have req  in  2  per-requester request, bit 0 = display reader, bit 1 = game writer.
REQ-007 The block SHALL have we  in  2  per-requester write(1)/read(0) select.
REQ-008 The block SHALL have addr  in  2*ADDR_W  per-requester address, requester i at [i*ADDR_W +: ADDR_W].
REQ-009 The block SHALL have wdata  in  2*DATA_W  per-requester write data, same packing.
REQ-010 The block SHALL have gnt  out  2  one-cycle grant pulse per requester.
REQ-011 The block SHALL have done  out  2  one-cycle completion pulse per requester.
REQ-012 The block SHALL have rdata  out  DATA_W  read result, valid with done.
REQ-013 The block SHALL have err  out  1  timeout flag, valid with done.
REQ-014 The block SHALL have busy  out  1  high whenever state is not IDLE.
REQ-015 The block SHALL have write, read  out  1 each  FIFO request strobes.
REQ-016 The block SHALL have writeaddr, readaddr  out  ADDR_W; writedata  out  DATA_W.
REQ-017 The block SHALL have wr_full, rd_empty  in  1 each; readdata  in  DATA_W.

Function
REQ-018 FSM states SHALL be IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT.
REQ-019 In IDLE with any req high, the arbiter SHALL pick a winner, latch its we/addr/wdata, and go to WR_ISSUE or RD_ISSUE on the next edge.
REQ-020 gnt[winner] SHALL be high for exactly the ISSUE cycle; req SHALL be ignored outside IDLE.
REQ-021 WR_ISSUE SHALL assert write for one cycle with latched writeaddr/writedata, then go to WR_WAIT.
REQ-022 WR_WAIT SHALL stay while wr_full=1; on wr_full=0 it SHALL pulse done[winner], err=0, and return to IDLE.
REQ-023 RD_ISSUE SHALL assert read for one cycle with latched readaddr, then go to RD_WAIT.
REQ-024 RD_WAIT SHALL stay while rd_empty=1; on rd_empty=0 it SHALL register readdata into rdata, pulse done[winner], and return to IDLE.
REQ-025 A WAIT counter SHALL clear on ISSUE and increment per WAIT cycle; on reaching TIMEOUT it SHALL pulse done[winner] with err=1, rdata=0, and return to IDLE.
REQ-026 Minimum turnaround SHALL be 3 cycles from req sample to the next IDLE; done SHALL never coincide with gnt.
REQ-027 Strobes and addr/data outputs SHALL be zero outside their ISSUE state.
REQ-028 Simultaneous req: arbitration SHALL follow REQ-032/033; the loser stays pending, unacknowledged.

Reset
REQ-029 Reset SHALL force IDLE immediately, regardless of state.
REQ-030 On reset, gnt, done, rdata, err, busy, write, read, all addresses and data SHALL be 0, the counter 0, and the round-robin pointer favour requester 0.
REQ-031 Reset mid-transaction SHALL abort it without a done pulse.

Configuration
REQ-032 With VRAM_ARB_ROUND_ROBIN_EN defined, the last-granted requester SHALL get lowest priority on the next contested grant.
REQ-033 Without VRAM_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win contention; the pointer logic SHALL be absent.

Verification
REQ-034 req=01, we=0, addr0=0x0003, rd_empty low 2 cycles after read, readdata=0x0003 -> gnt=01, read pulse with readaddr=0x0003, done=01, rdata=0x0003, err=0.
REQ-035 req=10, we=10, addr1=0x0001, wdata1=0x00AA, wr_full high 4 cycles -> write pulse with writeaddr=0x0001, writedata=0x00AA; done=10 after wr_full falls.
REQ-036 req=11 held for 4 transactions -> round-robin: grants 01,10,01,10; fixed-priority build: grants 01,01,01,01.
REQ-037 Read with rd_empty stuck at 1, TIMEOUT=255 -> done pulse 255 cycles after RD_WAIT entry, err=1, rdata=0x0000.
REQ-038 Reset asserted in WR_WAIT -> outputs all 0 same cycle, no done; after release, req=01 gets gnt=01 in the 2nd cycle.
